// File: rtl/mem_stage_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_access_ctrl_if
// Description : EX/MEM latched memory fields plus the datapath-to-dcache
//               request/response port, grouped for the MEM-stage controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_access_ctrl_if;
  // EX/MEM register outputs
  logic        dREN_EX_MEM;
  logic        dWEN_EX_MEM;
  logic        halt_EX_MEM;
  logic        flush_MEM;
  logic [31:0] dmemaddr_EX_MEM;
  logic [31:0] dmemstore_EX_MEM;
  // cache response
  logic        dhit;
  logic [31:0] dmemload;
  // cache request
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;

  // The MEM-stage controller drives the cache request side
  modport master (
    input  dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, flush_MEM,
    input  dmemaddr_EX_MEM, dmemstore_EX_MEM,
    input  dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore
  );

  // Pipeline register / cache side
  modport slave (
    output dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, flush_MEM,
    output dmemaddr_EX_MEM, dmemstore_EX_MEM,
    output dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_access_ctrl
// Description : MEM-stage data-memory access controller. Issues dcache
//               requests from the EX/MEM register, owns the dhit handshake,
//               generates the MEM stall, captures load data, latches halt,
//               and keeps saturating access/stall counters plus a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_access_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WATCHDOG = 1024
) (
  input  logic                          CLK,
  input  logic                          nRST,
  mem_stage_access_ctrl_if.master       bus,
  output logic                          mem_stall,
  output logic [31:0]                   load_data_MEM,
  output logic                          load_valid_MEM,
  output logic                          halt,
  output logic                          mem_error,
  output logic [CNT_W-1:0]              access_count,
  output logic [CNT_W-1:0]              stall_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        req;
  logic        active;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] store;
  logic        stall;
  logic        squash;
  logic        squash_now;
  logic        rd_done;
  logic        access_done;
  logic        illegal;
  logic        wd_expire;

  // A request is only issued from IDLE when the MEM instruction is not squashed
  assign req = (bus.dREN_EX_MEM | bus.dWEN_EX_MEM) & ~bus.flush_MEM;

  // Next-state and request/stall outputs; everything drops while nRST is low
  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    ren       = 1'b0;
    wen       = 1'b0;
    addr      = 32'h0;
    store     = 32'h0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          active = 1'b1;
          ren    = bus.dREN_EX_MEM;
          wen    = bus.dWEN_EX_MEM & ~bus.dREN_EX_MEM;  // read wins when both set
          addr   = bus.dmemaddr_EX_MEM;
          store  = bus.dmemstore_EX_MEM;
          stall  = ~bus.dhit;
          if (!bus.dhit) state_nxt = WAIT;
        end else if (bus.halt_EX_MEM && !bus.flush_MEM) begin
          state_nxt = HALTED;
        end
      end
      WAIT: begin
        // The cache cannot abort, so a flush here does not drop the request
        active = 1'b1;
        ren    = bus.dREN_EX_MEM;
        wen    = bus.dWEN_EX_MEM & ~bus.dREN_EX_MEM;
        addr   = bus.dmemaddr_EX_MEM;
        store  = bus.dmemstore_EX_MEM;
        stall  = ~bus.dhit;
        if (bus.dhit) state_nxt = IDLE;
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!nRST) begin
      active = 1'b0;
      ren    = 1'b0;
      wen    = 1'b0;
      addr   = 32'h0;
      store  = 32'h0;
      stall  = 1'b0;
    end
  end

  assign bus.dmemREN   = ren;
  assign bus.dmemWEN   = wen;
  assign bus.dmemaddr  = addr;
  assign bus.dmemstore = store;
  assign mem_stall     = stall;

  assign access_done = active & bus.dhit;
  assign rd_done     = ren & bus.dhit;
  assign illegal     = ren & bus.dWEN_EX_MEM;
  // A flush on the completing cycle of a waited access also squashes it
  assign squash_now  = squash | ((state == WAIT) & bus.flush_MEM);

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Sticky squash for the access in flight; cleared when it completes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                squash <= 1'b0;
    else if (state != WAIT || bus.dhit)       squash <= 1'b0;
    else if (bus.flush_MEM)                   squash <= 1'b1;
  end

  // Load result capture and one-cycle valid pulse for MEM/WB
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_data_MEM  <= 32'h0;
      load_valid_MEM <= 1'b0;
    end else begin
      load_valid_MEM <= rd_done & ~squash_now;
      if (rd_done) load_data_MEM <= bus.dmemload;
    end
  end

  // Sticky halt and error flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt      <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      if (state_nxt == HALTED)     halt      <= 1'b1;
      if (illegal || wd_expire)    mem_error <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      access_count <= '0;
      stall_count  <= '0;
    end else begin
      if (access_done && access_count != {CNT_W{1'b1}})
        access_count <= access_count + CNT_W'(1);
      if (stall && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  generate
    if (WATCHDOG > 0) begin : g_wd_on
      localparam int WD_W = $clog2(WATCHDOG + 1);
      logic [WD_W-1:0] wd_cnt;

      // Consecutive WAIT cycle counter, saturating at the limit
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
          wd_cnt <= '0;
        else if (state != WAIT)
          wd_cnt <= '0;
        else if (wd_cnt != WD_W'(WATCHDOG))
          wd_cnt <= wd_cnt + WD_W'(1);
      end

      // Expires at the end of the limit-th WAIT cycle without a dhit
      assign wd_expire = (state == WAIT) && !bus.dhit &&
                         (wd_cnt == WD_W'(WATCHDOG - 1));
    end else begin : g_wd_off
      assign wd_expire = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register. Takes the latched data-memory fields (dREN/dWEN/address/store data/halt) and drives the datapath-to-dcache request port.
- Owns the dhit handshake and generates the MEM-stage stall that holds IF/ID, ID/EX and EX/MEM.
- Captures load data for the MEM/WB register and latches processor halt.
- Sits between the EX/MEM register outputs and the cache/hazard unit.

Parameters:
- CNT_W, 16, width of saturating performance counters.
- WATCHDOG, 1024, max consecutive WAIT cycles before mem_error sets (0 disables).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- dREN_EX_MEM  input  1  latched load request.
- dWEN_EX_MEM  input  1  latched store request.
- halt_EX_MEM  input  1  latched halt instruction.
- flush_MEM  input  1  squash the instruction currently in MEM.
- dmemaddr_EX_MEM  input  32  latched effective address.
- dmemstore_EX_MEM  input  32  latched store data.
- dhit  input  1  cache completion strobe for the current request.
- dmemload  input  32  cache read data, valid when dhit.
- dmemREN  output  1  read request to cache.
- dmemWEN  output  1  write request to cache.
- dmemaddr  output  32  request address.
- dmemstore  output  32  request store data.
- mem_stall  output  1  hold upstream registers (enable_EX_MEM low).
- load_data_MEM  output  32  registered load result.
- load_valid_MEM  output  1  one-cycle pulse: load_data_MEM updated.
- halt  output  1  sticky processor halt.
- mem_error  output  1  sticky watchdog expiry.
- access_count  output  CNT_W  completed accesses, saturating.
- stall_count  output  CNT_W  cycles mem_stall high, saturating.

Behaviour:
- Reset (nRST low, async) values:
  - state=IDLE.
  - Registered outputs: load_data_MEM=0, load_valid_MEM=0, halt=0, mem_error=0, counters=0, watchdog count=0.
  - Combinational outputs are 0 while state=IDLE and no request is present.
- States: IDLE, WAIT, HALTED.
- IDLE:
  - req = (dREN_EX_MEM | dWEN_EX_MEM) & !flush_MEM.
  - dmemREN = dREN_EX_MEM & req; dmemWEN = dWEN_EX_MEM & req. dmemaddr/dmemstore pass through from EX/MEM.
  - mem_stall = req & !dhit.
  - req & dhit: stay IDLE, zero-wait access.
  - req & !dhit: go to WAIT.
  - halt_EX_MEM & !flush_MEM & !req: go to HALTED.
- WAIT:
  - Request outputs hold the EX/MEM values. EX/MEM is frozen by the stall, so the values are stable.
  - mem_stall = !dhit.
  - dhit: go to IDLE.
  - flush_MEM during WAIT does NOT drop the request, since the cache cannot abort. The access completes, but the load result is discarded (see below). A squashed store is still performed.
- HALTED:
  - dmemREN=dmemWEN=0, mem_stall=0, halt=1.
  - Only nRST exits HALTED.
- dREN and dWEN both high: illegal. The read wins (dmemWEN forced 0) and mem_error sets.
- Load capture: on the dhit cycle of a read, load_data_MEM <= dmemload at the next edge. load_valid_MEM pulses for one cycle unless a flush was seen at any point during the access.
  - Track this with a sticky squash bit, set by flush_MEM in WAIT and cleared on return to IDLE.
- Counters:
  - access_count += 1 on each dhit while in IDLE or WAIT.
  - stall_count += 1 each cycle mem_stall=1.
  - Both saturate at all-ones.
- Watchdog:
  - Counts consecutive WAIT cycles; cleared on leaving WAIT.
  - Reaching WATCHDOG sets mem_error (sticky until reset). The FSM keeps waiting.
- Async reset mid-WAIT: everything returns to reset values immediately and requests drop the same cycle.

Test Plan:
- Load to 0x0000_0040, dhit asserted same cycle with dmemload=0xDEAD_BEEF -> dmemREN=1 one cycle, mem_stall=0, load_data_MEM=0xDEAD_BEEF and load_valid_MEM=1 next cycle, access_count=1.
- Store 0x1234_5678 to 0x80, dhit delayed 3 cycles -> dmemWEN/addr/store held 4 cycles, mem_stall=1 for 3 cycles, stall_count=3, no load_valid pulse.
- Load in WAIT, flush_MEM pulsed in cycle 2, dhit in cycle 4 -> dmemREN stays high through cycle 4, load_valid_MEM never pulses, access_count increments.
- halt_EX_MEM with no request -> halt=1 next edge; a subsequent dREN_EX_MEM=1 produces dmemREN=0, mem_stall=0; nRST pulse clears halt.
- WATCHDOG=8, load with dhit never asserted -> mem_error=1 after 8 WAIT cycles, mem_stall stays 1; assert nRST mid-WAIT -> dmemREN=0 and mem_error=0 immediately.
- dREN and dWEN both 1 with dhit=1 -> dmemREN=1, dmemWEN=0, mem_error=1; preload stall_count to all-ones and stall once more -> value stays all-ones.
